// File: rtl/rx_pckg_pkg.sv
// Shared word layout, lock states and helpers for the receive packet checker.
// Pure definitions: no latency, no flow control.
package rx_pckg_pkg;

    localparam logic [3:0] SYNC_NIB = 4'hA;

    localparam int SYNC_HI = 23;
    localparam int SYNC_LO = 20;
    localparam int CH_HI   = 19;
    localparam int CH_LO   = 18;
    localparam int SEQ_HI  = 17;
    localparam int SEQ_LO  = 16;
    localparam int PAY_HI  = 15;
    localparam int PAY_LO  = 8;
    localparam int CHK_HI  = 7;
    localparam int CHK_LO  = 0;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] dat;
    } buf_entry_t;

    // Checksum covers the header byte (sync/ch/seq) and the payload byte.
    function automatic logic [7:0] calc_chk(input logic [7:0] hdr, input logic [7:0] pay);
        return hdr ^ pay;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_pckg_buf.sv
// FIFO of {ch, payload}; a push becomes visible on out_vld one clock later.
// Head holds while out_vld && !out_rdy; a push into a full FIFO is taken only alongside a pop.
module rx_pckg_buf
    import rx_pckg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  buf_entry_t push_dat,
    output logic       push_ok,
    output logic       out_vld,
    input  logic       out_rdy,
    output buf_entry_t out_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    buf_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            pop;
    logic            wr;

    assign out_vld = (count != '0);
    assign pop     = out_vld && out_rdy;
    assign push_ok = (count != FULL_CNT) || pop;
    assign wr      = push && push_ok;
    assign out_dat = mem[rd_ptr];

    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the popped slot is reused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_pckg_checker.sv
// Qualifies RX words (sync lock, checksum, channel, sequence) and buffers good payloads.
// One clock from rx_ena to out_vld when empty; words arriving at a full, stalled buffer are dropped and counted.
module rx_pckg_checker
    import rx_pckg_pkg::*;
#(
    parameter int LOCK_CNT  = 2,
    parameter int LOSS_CNT  = 3,
    parameter int BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_ena,
    input  logic [23:0] rx_data,
    input  logic        clr_err,
    input  logic        out_rdy,
    output logic        out_vld,
    output logic [1:0]  out_ch,
    output logic [7:0]  out_dat,
    output logic        locked,
    output logic [7:0]  err_sync,
    output logic [7:0]  err_chk,
    output logic [7:0]  err_seq,
    output logic [7:0]  err_ovf,
    output logic [15:0] pkt_cnt
);

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_LIM = 8'(LOSS_CNT);

    logic [3:0] sync_nib;
    logic [1:0] ch;
    logic [1:0] seq;
    logic [7:0] pay;
    logic [7:0] chk;
    logic       sync_ok;
    logic       good;

    assign sync_nib = rx_data[SYNC_HI:SYNC_LO];
    assign ch       = rx_data[CH_HI:CH_LO];
    assign seq      = rx_data[SEQ_HI:SEQ_LO];
    assign pay      = rx_data[PAY_HI:PAY_LO];
    assign chk      = rx_data[CHK_HI:CHK_LO];
    assign sync_ok  = (sync_nib == SYNC_NIB);
    assign good     = sync_ok && (ch != 2'd0) && (chk == calc_chk({sync_nib, ch, seq}, pay));

    lock_state_t state, state_nxt;
    logic [7:0]  good_cnt, good_nxt;
    logic [7:0]  loss_cnt, loss_nxt;
    logic        deliver;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            loss_cnt <= loss_nxt;
        end
    end

    // The word that completes lock is itself delivered.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        loss_nxt  = loss_cnt;
        deliver   = 1'b0;
        if (rx_ena) begin
            case (state)
                HUNT: begin
                    if (good) begin
                        if (LOCK_LIM <= 8'd1) begin
                            state_nxt = LOCKED;
                            good_nxt  = '0;
                            loss_nxt  = '0;
                            deliver   = 1'b1;
                        end else begin
                            state_nxt = CHECK;
                            good_nxt  = 8'd1;
                        end
                    end
                end
                CHECK: begin
                    if (!good) begin
                        state_nxt = HUNT;
                        good_nxt  = '0;
                    end else if (good_cnt + 8'd1 >= LOCK_LIM) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                        loss_nxt  = '0;
                        deliver   = 1'b1;
                    end else begin
                        good_nxt = good_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    if (!sync_ok) begin
                        if (loss_cnt + 8'd1 >= LOSS_LIM) begin
                            state_nxt = HUNT;
                            loss_nxt  = '0;
                        end else begin
                            loss_nxt = loss_cnt + 8'd1;
                        end
                    end else begin
                        loss_nxt = '0;
                        deliver  = good;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    good_nxt  = '0;
                    loss_nxt  = '0;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

    logic       push_ok;
    logic       accepted;
    logic       sync_err;
    logic       chk_err;
    logic       seq_err;
    logic       ovf_err;
    logic [3:0] seen;
    logic [1:0] exp_seq [4];
    buf_entry_t push_dat;
    buf_entry_t head;

    assign push_dat = '{ch: ch, dat: pay};
    assign accepted = deliver && push_ok;
    assign sync_err = rx_ena && (state == LOCKED) && !sync_ok;
    assign chk_err  = rx_ena && (state == LOCKED) && sync_ok && !good;
    assign seq_err  = deliver && seen[ch] && (seq != exp_seq[ch]);
    assign ovf_err  = deliver && !push_ok;

    rx_pckg_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (deliver),
        .push_dat (push_dat),
        .push_ok  (push_ok),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_dat  (head)
    );

    assign out_ch  = head.ch;
    assign out_dat = head.dat;

    // Sequence state follows every delivered word, even one dropped for overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen     <= '0;
            pkt_cnt  <= '0;
            err_sync <= '0;
            err_chk  <= '0;
            err_seq  <= '0;
            err_ovf  <= '0;
            for (int i = 0; i < 4; i++) begin
                exp_seq[i] <= '0;
            end
        end else begin
            if (deliver) begin
                seen[ch]    <= 1'b1;
                exp_seq[ch] <= seq + 2'd1;
            end
            if (accepted) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (clr_err) begin
                err_sync <= '0;
                err_chk  <= '0;
                err_seq  <= '0;
                err_ovf  <= '0;
            end else begin
                if (sync_err) err_sync <= sat_inc(err_sync);
                if (chk_err)  err_chk  <= sat_inc(err_chk);
                if (seq_err)  err_seq  <= sat_inc(err_seq);
                if (ovf_err)  err_ovf  <= sat_inc(err_ovf);
            end
        end
    end

endmodule

// File: tb/tb_rx_pckg_checker.sv
// Directed bench for rx_pckg_checker with a scoreboard queue for delivered entries.
module tb_rx_pckg_checker;

    logic        clk;
    logic        rst_n;
    logic        rx_ena;
    logic [23:0] rx_data;
    logic        clr_err;
    logic        out_rdy;
    logic        out_vld;
    logic [1:0]  out_ch;
    logic [7:0]  out_dat;
    logic        locked;
    logic [7:0]  err_sync;
    logic [7:0]  err_chk;
    logic [7:0]  err_seq;
    logic [7:0]  err_ovf;
    logic [15:0] pkt_cnt;

    int tests;
    int fails;
    logic [9:0] exp_q [$];

    rx_pckg_checker #(
        .LOCK_CNT  (2),
        .LOSS_CNT  (3),
        .BUF_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_ena   (rx_ena),
        .rx_data  (rx_data),
        .clr_err  (clr_err),
        .out_rdy  (out_rdy),
        .out_vld  (out_vld),
        .out_ch   (out_ch),
        .out_dat  (out_dat),
        .locked   (locked),
        .err_sync (err_sync),
        .err_chk  (err_chk),
        .err_seq  (err_seq),
        .err_ovf  (err_ovf),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [1:0] ch, input logic [1:0] seq, input logic [7:0] pay);
        logic [7:0] hdr;
        hdr = {4'hA, ch, seq};
        return {hdr, pay, hdr ^ pay};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] w);
        @(posedge clk);
        #1;
        rx_ena  = 1'b1;
        rx_data = w;
        @(posedge clk);
        #1;
        rx_ena  = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [7:0] dat);
        exp_q.push_back({ch, dat});
    endtask

    // Each handshake seen on the output is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL pop_unexpected: observed ch=%0d dat=0x%0h expected no entry", out_ch, out_dat);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                assert ({out_ch, out_dat} === e) else begin
                    fails++;
                    $error("FAIL pop_entry: observed 0x%0h expected 0x%0h", {out_ch, out_dat}, e);
                end
            end
        end
    end

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        rx_ena  = 1'b0;
        rx_data = '0;
        clr_err = 1'b0;
        out_rdy = 1'b0;
        tick(3);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_errs", 32'({err_sync, err_chk, err_seq, err_ovf}), 32'd0);
        check("rst_out_dat", 32'({out_ch, out_dat}), 32'd0);
        rst_n = 1'b1;

        // Lock on two good ch1 words; only the second is delivered.
        send(24'hA455F1);
        check("hunt_locked", 32'(locked), 32'd0);
        check("hunt_out_vld", 32'(out_vld), 32'd0);
        push_exp(2'd1, 8'h55);
        send(24'hA455F1);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_out_vld", 32'(out_vld), 32'd1);
        check("lock_head", 32'({out_ch, out_dat}), 32'({2'd1, 8'h55}));
        check("lock_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("lock_errs", 32'({err_sync, err_chk, err_seq, err_ovf}), 32'd0);
        out_rdy = 1'b1;
        tick(1);
        check("lock_drained", 32'(out_vld), 32'd0);

        // Repeated ch2 seq1 word: second one is a sequence error but still delivered.
        push_exp(2'd2, 8'h3C);
        send(24'hA93C95);
        check("seq_first_err", 32'(err_seq), 32'd0);
        push_exp(2'd2, 8'h3C);
        send(24'hA93C95);
        check("seq_second_err", 32'(err_seq), 32'd1);
        tick(1);
        check("seq_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // Bad checksum: dropped, lock kept. Three sync errors then lose lock.
        send(24'hA455F0);
        check("chk_err", 32'(err_chk), 32'd1);
        check("chk_locked", 32'(locked), 32'd1);
        check("chk_no_out", 32'(out_vld), 32'd0);
        send(24'h5455F1);
        send(24'h5455F1);
        check("loss_still_locked", 32'(locked), 32'd1);
        send(24'h5455F1);
        check("loss_err_sync", 32'(err_sync), 32'd3);
        check("loss_unlocked", 32'(locked), 32'd0);

        // Relock on ch3, then fill the stalled buffer past capacity.
        send(mk(2'd3, 2'd0, 8'h11));
        push_exp(2'd3, 8'h11);
        send(mk(2'd3, 2'd0, 8'h11));
        check("relock_locked", 32'(locked), 32'd1);
        tick(1);
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_exp(2'd1, 8'hA0 + 8'(i));
            send(mk(2'd1, 2'(i + 1), 8'hA0 + 8'(i)));
        end
        check("ovf_err", 32'(err_ovf), 32'd1);
        check("ovf_pkt_cnt", 32'(pkt_cnt), 32'd8);
        check("ovf_head_hold", 32'({out_ch, out_dat}), 32'({2'd1, 8'hA0}));
        check("ovf_no_seq_err", 32'(err_seq), 32'd1);

        // Full buffer: push and pop in the same cycle must not overflow.
        @(posedge clk);
        #1;
        rx_ena  = 1'b1;
        rx_data = mk(2'd1, 2'd2, 8'hB0);
        out_rdy = 1'b1;
        push_exp(2'd1, 8'hB0);
        @(posedge clk);
        #1;
        rx_ena  = 1'b0;
        out_rdy = 1'b0;
        check("fullpp_ovf", 32'(err_ovf), 32'd1);
        check("fullpp_pkt_cnt", 32'(pkt_cnt), 32'd9);
        check("fullpp_seq", 32'(err_seq), 32'd1);
        out_rdy = 1'b1;
        tick(3);
        check("fullpp_occ_gt3", 32'(out_vld), 32'd1);
        tick(1);
        check("fullpp_occ_4", 32'(out_vld), 32'd0);
        check("fullpp_q_empty", 32'(exp_q.size()), 32'd0);

        // Saturate err_sync while keeping lock via sync-ok bad-checksum words.
        for (int r = 0; r < 126; r++) begin
            send(24'h5455F1);
            send(24'h5455F1);
            send(mk(2'd3, 2'd1, 8'h22) ^ 24'h000001);
        end
        check("sat_reach", 32'(err_sync), 32'hFF);
        check("sat_chk", 32'(err_chk), 32'd127);
        send(24'h5455F1);
        check("sat_hold", 32'(err_sync), 32'hFF);
        check("sat_locked", 32'(locked), 32'd1);

        @(posedge clk);
        #1;
        rx_ena  = 1'b1;
        rx_data = 24'h5455F1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        rx_ena  = 1'b0;
        clr_err = 1'b0;
        check("clr_err_sync", 32'(err_sync), 32'd0);
        check("clr_err_others", 32'({err_chk, err_seq, err_ovf}), 32'd0);
        check("clr_pkt_kept", 32'(pkt_cnt), 32'd9);

        // Reset with two entries buffered discards them.
        out_rdy = 1'b0;
        send(mk(2'd3, 2'd1, 8'hC1));
        send(mk(2'd3, 2'd2, 8'hC2));
        check("prerst_head", 32'({out_vld, out_ch, out_dat}), 32'({1'b1, 2'd3, 8'hC1}));
        check("prerst_seq", 32'(err_seq), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_vld", 32'(out_vld), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        tick(2);
        check("postrst_empty", 32'(out_vld), 32'd0);

        // Seen flags were cleared: a ch1 seq0 word is not a sequence error.
        send(mk(2'd1, 2'd0, 8'hD0));
        push_exp(2'd1, 8'hD0);
        send(mk(2'd1, 2'd0, 8'hD0));
        check("postrst_locked", 32'(locked), 32'd1);
        check("postrst_seq", 32'(err_seq), 32'd0);
        tick(2);
        check("postrst_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
